// File: rtl/shift_register_universal_pkg.sv
// shift_register_pkg: mode, FSM state and stage-operation types shared by the universal shift register.
package shift_register_pkg;

    typedef enum logic [2:0] {
        M_HOLD     = 3'd0,
        M_SHIFT_UP = 3'd1,
        M_SHIFT_DN = 3'd2,
        M_ROT_UP   = 3'd3,
        M_ROT_DN   = 3'd4,
        M_LOAD     = 3'd5,
        M_BURST    = 3'd6,
        M_RSVD     = 3'd7
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_UP   = 3'd1,
        OP_DN   = 3'd2,
        OP_RUP  = 3'd3,
        OP_RDN  = 3'd4,
        OP_LOAD = 3'd5
    } op_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_register_universal_if.sv
// shift_register_universal_if: control, serial and parallel signals of the universal shift register.
interface shift_register_universal_if #(
    parameter int N = 4,
    parameter int W = 1
);
    logic           en;
    logic [2:0]     mode;
    logic [W-1:0]   sin_lo;
    logic [W-1:0]   sin_hi;
    logic [N*W-1:0] pin;
    logic [N*W-1:0] pout;
    logic [W-1:0]   sout_hi;
    logic [W-1:0]   sout_lo;
    logic           busy;
    logic           sout_last;
    logic           done;

    modport master (
        output en, mode, sin_lo, sin_hi, pin,
        input  pout, sout_hi, sout_lo, busy, sout_last, done
    );

    modport slave (
        input  en, mode, sin_lo, sin_hi, pin,
        output pout, sout_hi, sout_lo, busy, sout_last, done
    );
endinterface

// File: rtl/shift_register_universal_burst_ctrl.sv
// shift_register_burst_ctrl: burst FSM and per-cycle stage operation decode.
// Build option: SHIFT_REGISTER_UNIVERSAL_ROTATE_EN maps modes 3/4 to rotates, otherwise to hold.
module shift_register_burst_ctrl
    import shift_register_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en_i,
    input  logic [2:0] mode_i,
    output op_e        op_o,
    output logic       busy_o,
    output logic       sout_last_o,
    output logic       done_o
);
    localparam int CW = cnt_width(N);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          last;

    assign last        = cnt_q == CW'(N - 1);
    assign busy_o      = state_q == S_RUN;
    assign sout_last_o = busy_o && last;
    assign done_o      = done_q;

    always_comb begin
        op_o = OP_HOLD;
        if (en_i && state_q == S_RUN) begin
            op_o = last ? OP_HOLD : OP_UP;
        end else if (en_i) begin
            case (mode_e'(mode_i))
                M_SHIFT_UP: op_o = OP_UP;
                M_SHIFT_DN: op_o = OP_DN;
`ifdef SHIFT_REGISTER_UNIVERSAL_ROTATE_EN
                M_ROT_UP:   op_o = OP_RUP;
                M_ROT_DN:   op_o = OP_RDN;
`else
                M_ROT_UP,
                M_ROT_DN:   op_o = OP_HOLD;
`endif
                M_LOAD,
                M_BURST:    op_o = OP_LOAD;
                default:    op_o = OP_HOLD;
            endcase
        end
    end

    // done is a single-cycle pulse: it drops on the next edge even if en is low
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en_i && state_q == S_IDLE && mode_e'(mode_i) == M_BURST) begin
                state_q <= S_RUN;
                cnt_q   <= '0;
            end else if (en_i && state_q == S_RUN && last) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
            end else if (en_i && state_q == S_RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/shift_register_universal.sv
// shift_register_universal: N x W universal shift register with hold/shift/rotate/load and burst serialiser.
// Build option: SHIFT_REGISTER_UNIVERSAL_ROTATE_EN builds the rotate paths for modes 3/4.
module shift_register_universal
    import shift_register_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 1
) (
    input logic                       clk,
    input logic                       clear,
    shift_register_universal_if.slave bus
);
    op_e                 op;
    logic [N-1:0][W-1:0] stage_q;
    logic [N-1:0][W-1:0] stage_d;

    shift_register_burst_ctrl #(.N(N)) u_ctrl (
        .clk        (clk),
        .clear      (clear),
        .en_i       (bus.en),
        .mode_i     (bus.mode),
        .op_o       (op),
        .busy_o     (bus.busy),
        .sout_last_o(bus.sout_last),
        .done_o     (bus.done)
    );

    for (genvar i = 0; i < N; i++) begin : g_stage
        logic [W-1:0] up;
        logic [W-1:0] dn;
        logic [W-1:0] rup;
        logic [W-1:0] rdn;
        if (i == 0) begin : g_first
            assign up = bus.sin_lo;
        end else begin : g_up
            assign up = stage_q[i-1];
        end
        if (i == N - 1) begin : g_last
            assign dn = bus.sin_hi;
        end else begin : g_dn
            assign dn = stage_q[i+1];
        end
`ifdef SHIFT_REGISTER_UNIVERSAL_ROTATE_EN
        // with N=1 both neighbours wrap to the stage itself, so rotates hold
        assign rup = stage_q[(i + N - 1) % N];
        assign rdn = stage_q[(i + 1) % N];
`else
        assign rup = stage_q[i];
        assign rdn = stage_q[i];
`endif
        assign stage_d[i] = op == OP_UP   ? up :
                            op == OP_DN   ? dn :
                            op == OP_RUP  ? rup :
                            op == OP_RDN  ? rdn :
                            op == OP_LOAD ? bus.pin[i*W +: W] : stage_q[i];
    end

    always_ff @(posedge clk) begin
        stage_q <= clear ? '0 : stage_d;
    end

    assign bus.pout    = stage_q;
    assign bus.sout_hi = stage_q[N-1];
    assign bus.sout_lo = stage_q[0];
endmodule

// File: tb/tb_shift_register_universal.sv
// tb_shift_register_universal: vector table, corner sequences and randomized model check.
module tb_shift_register_universal;
    localparam logic [2:0] HOLD = 3'd0, SUP = 3'd1, SDN = 3'd2, RUP = 3'd3, RDN = 3'd4,
                           LOAD = 3'd5, BURST = 3'd6, RSVD = 3'd7;
`ifdef SHIFT_REGISTER_UNIVERSAL_ROTATE_EN
    localparam logic [31:0] ROT_EXP = 32'h33221144;
`else
    localparam logic [31:0] ROT_EXP = 32'h44332211;
`endif

    typedef struct {
        logic        clr;
        logic        en;
        logic [2:0]  mode;
        logic [7:0]  slo;
        logic [7:0]  shi;
        logic [31:0] pin;
        logic [31:0] pout;
        logic        busy;
        logic        last;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic clr4;
    logic clr1;
    int   passed = 0;
    int   total = 0;
    vec_t vecs[20];

    logic [31:0] mv;
    int          mrem;
    logic        mdone;

    always #5 clk = ~clk;

    shift_register_universal_if #(.N(4), .W(8)) b4 ();
    shift_register_universal_if #(.N(1), .W(8)) b1 ();

    shift_register_universal #(.N(4), .W(8)) dut4 (.clk(clk), .clear(clr4), .bus(b4));
    shift_register_universal #(.N(1), .W(8)) dut1 (.clk(clk), .clear(clr1), .bus(b1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic c, input logic e, input logic [2:0] m,
                          input logic [7:0] lo, input logic [7:0] hi, input logic [31:0] p);
        clr4 = c; b4.en = e; b4.mode = m; b4.sin_lo = lo; b4.sin_hi = hi; b4.pin = p;
    endtask

    task automatic drive1(input logic e, input logic [2:0] m,
                          input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] p);
        clr1 = 1'b0; b1.en = e; b1.mode = m; b1.sin_lo = lo; b1.sin_hi = hi; b1.pin = p;
    endtask

    task automatic check4(input string tag, input logic [31:0] p,
                          input logic bsy, input logic lst, input logic dn);
        check({tag, " pout"}, b4.pout, p);
        check({tag, " sout_hi"}, 32'(b4.sout_hi), 32'(p[31:24]));
        check({tag, " sout_lo"}, 32'(b4.sout_lo), 32'(p[7:0]));
        check({tag, " busy"}, 32'(b4.busy), 32'(bsy));
        check({tag, " sout_last"}, 32'(b4.sout_last), 32'(lst));
        check({tag, " done"}, 32'(b4.done), 32'(dn));
    endtask

    task automatic check1(input string tag, input logic [7:0] p,
                          input logic bsy, input logic lst, input logic dn);
        check({tag, " pout"}, 32'(b1.pout), 32'(p));
        check({tag, " sout_hi"}, 32'(b1.sout_hi), 32'(p));
        check({tag, " sout_lo"}, 32'(b1.sout_lo), 32'(p));
        check({tag, " busy"}, 32'(b1.busy), 32'(bsy));
        check({tag, " sout_last"}, 32'(b1.sout_last), 32'(lst));
        check({tag, " done"}, 32'(b1.done), 32'(dn));
    endtask

    // Word-level model: a burst is a count of symbols still to be presented on sout_hi
    task automatic model_step(input logic c, input logic e, input logic [2:0] m,
                              input logic [7:0] lo, input logic [7:0] hi, input logic [31:0] p);
        logic nd;
        nd = 1'b0;
        if (c) begin
            mv = '0;
            mrem = 0;
        end else if (e && mrem > 0) begin
            mrem--;
            if (mrem == 0) nd = 1'b1;
            else mv = {mv[23:0], lo};
        end else if (e) begin
            case (m)
                SUP:   mv = {mv[23:0], lo};
                SDN:   mv = {hi, mv[31:8]};
`ifdef SHIFT_REGISTER_UNIVERSAL_ROTATE_EN
                RUP:   mv = {mv[23:0], mv[31:24]};
                RDN:   mv = {mv[7:0], mv[31:8]};
`endif
                LOAD:  mv = p;
                BURST: begin mv = p; mrem = 4; end
                default: mv = mv;
            endcase
        end
        mdone = nd;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, LOAD,  8'h00, 8'h00, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, LOAD,  8'h00, 8'h00, 32'h44332211, 32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, SUP,   8'hAA, 8'h00, 32'h0,        32'h332211AA, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, LOAD,  8'h00, 8'h00, 32'h44332211, 32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, SDN,   8'h00, 8'hEE, 32'h0,        32'hEE443322, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, SDN,   8'h00, 8'hEE, 32'h0,        32'hEEEE4433, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, LOAD,  8'h00, 8'h00, 32'h44332211, 32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, RUP,   8'h00, 8'h00, 32'h0,        ROT_EXP,      1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, RDN,   8'h00, 8'h00, 32'h0,        32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, RSVD,  8'h55, 8'h66, 32'h12345678, 32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, HOLD,  8'h55, 8'h66, 32'h12345678, 32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, LOAD,  8'h55, 8'h66, 32'h12345678, 32'h44332211, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, BURST, 8'h00, 8'h00, 32'hDDCCBBAA, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, LOAD,  8'h01, 8'h00, 32'hFFFFFFFF, 32'hCCBBAA01, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, SUP,   8'h77, 8'h00, 32'h0,        32'hCCBBAA01, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, SUP,   8'h77, 8'h00, 32'h0,        32'hCCBBAA01, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, HOLD,  8'h02, 8'h00, 32'h0,        32'hBBAA0102, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, SDN,   8'h03, 8'h00, 32'h0,        32'hAA010203, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, HOLD,  8'h04, 8'h00, 32'h0,        32'hAA010203, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, HOLD,  8'h05, 8'h00, 32'h0,        32'hAA010203, 1'b0, 1'b0, 1'b0};

        clr1 = 1'b1; b1.en = 1'b0; b1.mode = HOLD; b1.sin_lo = '0; b1.sin_hi = '0; b1.pin = '0;
        for (int k = 0; k < 20; k++) begin
            drive4(vecs[k].clr, vecs[k].en, vecs[k].mode, vecs[k].slo, vecs[k].shi, vecs[k].pin);
            tick();
            if (k == 0) check1("n1 reset", 8'h00, 1'b0, 1'b0, 1'b0);
            clr1 = 1'b0;
            check4($sformatf("vec%0d", k), vecs[k].pout, vecs[k].busy, vecs[k].last, vecs[k].done);
        end

        // back-to-back bursts, mode held at BURST throughout
        drive4(1'b0, 1'b1, BURST, 8'h00, 8'h00, 32'h01020304);
        tick(); check4("b2b acc", 32'h01020304, 1'b1, 1'b0, 1'b0);
        b4.pin = 32'hA0B0C0D0;
        tick(); check4("b2b s1", 32'h02030400, 1'b1, 1'b0, 1'b0);
        tick(); check4("b2b s2", 32'h03040000, 1'b1, 1'b0, 1'b0);
        tick(); check4("b2b s3", 32'h04000000, 1'b1, 1'b1, 1'b0);
        tick(); check4("b2b done", 32'h04000000, 1'b0, 1'b0, 1'b1);
        tick(); check4("b2b acc2", 32'hA0B0C0D0, 1'b1, 1'b0, 1'b0);
        drive4(1'b1, 1'b0, HOLD, 8'h00, 8'h00, 32'h0);
        tick(); check4("b2b clr", 32'h0, 1'b0, 1'b0, 1'b0);

        // clear at cnt=2 aborts without done; next BURST accepted
        drive4(1'b0, 1'b1, BURST, 8'h55, 8'h00, 32'h11223344);
        tick(); check4("abort acc", 32'h11223344, 1'b1, 1'b0, 1'b0);
        b4.mode = HOLD;
        tick(); check4("abort s1", 32'h22334455, 1'b1, 1'b0, 1'b0);
        tick(); check4("abort s2", 32'h33445555, 1'b1, 1'b0, 1'b0);
        clr4 = 1'b1;
        tick(); check4("abort clr", 32'h0, 1'b0, 1'b0, 1'b0);
        drive4(1'b0, 1'b1, BURST, 8'h00, 8'h00, 32'h99887766);
        tick(); check4("abort new", 32'h99887766, 1'b1, 1'b0, 1'b0);
        b4.en = 1'b0;

        // single-stage register
        drive1(1'b1, LOAD, 8'h00, 8'h00, 8'hA5); tick(); check1("n1 load", 8'hA5, 1'b0, 1'b0, 1'b0);
        drive1(1'b1, SUP,  8'h3C, 8'h00, 8'h00); tick(); check1("n1 sup", 8'h3C, 1'b0, 1'b0, 1'b0);
        drive1(1'b1, SDN,  8'h00, 8'h7E, 8'h00); tick(); check1("n1 sdn", 8'h7E, 1'b0, 1'b0, 1'b0);
        drive1(1'b1, RUP,  8'h00, 8'h00, 8'h00); tick(); check1("n1 rot", 8'h7E, 1'b0, 1'b0, 1'b0);
        drive1(1'b1, BURST, 8'h11, 8'h22, 8'h5A); tick(); check1("n1 burst", 8'h5A, 1'b1, 1'b1, 1'b0);
        drive1(1'b1, HOLD, 8'h11, 8'h22, 8'h00); tick(); check1("n1 done", 8'h5A, 1'b0, 1'b0, 1'b1);
        tick(); check1("n1 idle", 8'h5A, 1'b0, 1'b0, 1'b0);
        b1.en = 1'b0;

        // randomized run against the word-level model
        drive4(1'b1, 1'b0, HOLD, 8'h00, 8'h00, 32'h0);
        tick();
        model_step(1'b1, 1'b0, HOLD, 8'h00, 8'h00, 32'h0);
        mdone = 1'b0;
        for (int t = 0; t < 400; t++) begin
            logic       c, e;
            logic [2:0] m;
            logic [7:0] lo, hi;
            logic [31:0] p;
            c  = $urandom_range(0, 39) == 0;
            e  = mdone ? 1'b1 : ($urandom_range(0, 4) != 0);
            m  = ($urandom_range(0, 3) == 0) ? BURST : 3'($urandom_range(0, 7));
            lo = 8'($urandom);
            hi = 8'($urandom);
            p  = $urandom;
            drive4(c, e, m, lo, hi, p);
            tick();
            model_step(c, e, m, lo, hi, p);
            check4($sformatf("rand%0d", t), mv, mrem > 0, mrem == 1, mdone);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
